// File: rtl/mono_data_rx_mux.sv
// Per-channel hit buffers merged round-robin into tagged 32-bit readout words.
// Define MONO_RX_MUX_TIMESTAMP_EN to buffer TIMESTAMP[23:0] per hit and emit a third word.
module mono_data_rx_mux #(
  parameter int         ABUSWIDTH  = 16,
  parameter int         N_CH       = 4,
  parameter int         CH_ASIZE   = 2,
  parameter logic [1:0] IDENTIFIER = 2'b00
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic [N_CH-1:0]      CH_STROBE,
  input  logic [30*N_CH-1:0]   CH_DATA,
  input  logic [63:0]          TIMESTAMP,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  output logic                 LOST_ERROR
);

`ifdef MONO_RX_MUX_TIMESTAMP_EN
  localparam int BW = 54;
  typedef enum logic [1:0] {IDLE, W1DONE, W2DONE} state_t;
`else
  localparam int BW = 30;
  typedef enum logic {IDLE, W1DONE} state_t;
`endif
  localparam int DEPTH = 1 << CH_ASIZE;

  logic            rst;
  logic [N_CH-1:0] conf_en;
  logic            conf_disable_gray;
  logic [N_CH-1:0] ch_empty;
  logic [N_CH-1:0] ch_full;
  logic [N_CH-1:0] ch_pop;
  logic [N_CH-1:0] req;
  logic [BW-1:0]   ch_head [N_CH];
  logic [7:0]      lost_cnt [N_CH];
  logic [3:0]      last_grant;
  logic [3:0]      grant_ch;
  logic            any_req;
  logic            grant;
  int              idx;
  logic [BW-1:0]   head;
  logic [7:0]      le_dec;
  logic [7:0]      te_dec;
  state_t          state;
  logic            slot_valid;
  logic [29:0]     slot_data;
  logic            slot_free;
  logic [5:0]      hit_col;
  logic [3:0]      hit_ch;
  logic [7:0]      rd_mux;
  logic            unused_ok;

  // A write to address 0 doubles as a soft reset of the whole block.
  assign rst = BUS_RST | (BUS_WR && (BUS_ADD == ABUSWIDTH'(0)));

  assign unused_ok = ^{TIMESTAMP, BUS_DATA_IN};

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      conf_en           <= '0;
      conf_disable_gray <= 1'b0;
    end else if (BUS_WR) begin
      if (BUS_ADD == ABUSWIDTH'(2)) conf_en <= BUS_DATA_IN[N_CH-1:0];
      if (BUS_ADD == ABUSWIDTH'(3)) conf_disable_gray <= BUS_DATA_IN[0];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [BW-1:0]     mem [DEPTH];
    logic [CH_ASIZE:0] wr_ptr;
    logic [CH_ASIZE:0] rd_ptr;
    logic [BW-1:0]     wdata;
    logic              push;
    logic              drop;
    logic [7:0]        lost;

`ifdef MONO_RX_MUX_TIMESTAMP_EN
    assign wdata = {TIMESTAMP[23:0], CH_DATA[30*i +: 30]};
`else
    assign wdata = CH_DATA[30*i +: 30];
`endif
    assign ch_empty[i] = (wr_ptr == rd_ptr);
    assign ch_full[i]  = (wr_ptr[CH_ASIZE] != rd_ptr[CH_ASIZE]) &&
                         (wr_ptr[CH_ASIZE-1:0] == rd_ptr[CH_ASIZE-1:0]);
    assign ch_head[i]  = mem[rd_ptr[CH_ASIZE-1:0]];
    assign ch_pop[i]   = grant && (grant_ch == 4'(i));
    // A full buffer still accepts a hit when its head leaves in the same cycle.
    assign push        = CH_STROBE[i] && conf_en[i] && (!ch_full[i] || ch_pop[i]);
    assign drop        = CH_STROBE[i] && conf_en[i] && ch_full[i] && !ch_pop[i];
    assign lost_cnt[i] = lost;

    always_ff @(posedge BUS_CLK) begin
      if (push) mem[wr_ptr[CH_ASIZE-1:0]] <= wdata;
    end

    always_ff @(posedge BUS_CLK) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lost   <= 8'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (ch_pop[i]) rd_ptr <= rd_ptr + 1'b1;
        if (drop && (lost != 8'hFF)) lost <= lost + 8'd1;
      end
    end
  end

  assign req = ~ch_empty & conf_en;

  // Rotating priority: the channel after the last grant is searched first.
  always_comb begin
    any_req  = 1'b0;
    grant_ch = 4'd0;
    idx      = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      for (int j = 0; j < N_CH; j++) begin
        if (!any_req && (idx == j) && req[j]) begin
          any_req  = 1'b1;
          grant_ch = 4'(j);
        end
      end
    end
  end

  assign slot_free = !slot_valid || FIFO_READ;
  assign grant     = any_req && (state == IDLE) && slot_free;

  always_comb begin
    head = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (grant_ch == 4'(j)) head = ch_head[j];
    end
  end

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  assign le_dec = conf_disable_gray ? head[29:22] : gray2bin(head[29:22]);
  assign te_dec = conf_disable_gray ? head[21:14] : gray2bin(head[21:14]);

`ifdef MONO_RX_MUX_TIMESTAMP_EN
  logic [23:0] hit_ts;
`endif

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state      <= IDLE;
      slot_valid <= 1'b0;
      slot_data  <= '0;
      hit_col    <= '0;
      hit_ch     <= '0;
      last_grant <= 4'(N_CH - 1);
`ifdef MONO_RX_MUX_TIMESTAMP_EN
      hit_ts     <= '0;
`endif
    end else begin
      if (slot_valid && FIFO_READ) slot_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            slot_data  <= {2'b01, grant_ch, le_dec, te_dec, head[13:6]};
            slot_valid <= 1'b1;
            hit_col    <= head[5:0];
            hit_ch     <= grant_ch;
            last_grant <= grant_ch;
`ifdef MONO_RX_MUX_TIMESTAMP_EN
            hit_ts     <= head[53:30];
`endif
            state      <= W1DONE;
          end
        end
        W1DONE: begin
          if (slot_free) begin
            slot_data  <= {2'b10, hit_ch, 18'd0, hit_col};
            slot_valid <= 1'b1;
`ifdef MONO_RX_MUX_TIMESTAMP_EN
            state      <= W2DONE;
`else
            state      <= IDLE;
`endif
          end
        end
`ifdef MONO_RX_MUX_TIMESTAMP_EN
        W2DONE: begin
          if (slot_free) begin
            slot_data  <= {2'b11, hit_ch, hit_ts};
            slot_valid <= 1'b1;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign FIFO_EMPTY = ~slot_valid;
  assign FIFO_DATA  = {IDENTIFIER, slot_data};

  always_comb begin
    rd_mux = 8'd0;
    if (BUS_ADD == ABUSWIDTH'(0))      rd_mux = 8'd1;
    else if (BUS_ADD == ABUSWIDTH'(2)) rd_mux = 8'(conf_en);
    else if (BUS_ADD == ABUSWIDTH'(3)) rd_mux = {7'd0, conf_disable_gray};
    for (int j = 0; j < N_CH; j++) begin
      if (BUS_ADD == ABUSWIDTH'(4 + j)) rd_mux = lost_cnt[j];
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst)         BUS_DATA_OUT <= 8'd0;
    else if (BUS_RD) BUS_DATA_OUT <= rd_mux;
  end

  always_comb begin
    LOST_ERROR = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (lost_cnt[j] != 8'd0) LOST_ERROR = 1'b1;
    end
  end

endmodule

// File: tb/tb_mono_data_rx_mux.sv
// Directed self-checking bench for mono_data_rx_mux (default parameters).
// Timestamp-word checks are compiled in when MONO_RX_MUX_TIMESTAMP_EN is defined.
module tb_mono_data_rx_mux;
  localparam int N_CH = 4;
`ifdef MONO_RX_MUX_TIMESTAMP_EN
  localparam int WPH = 3;
`else
  localparam int WPH = 2;
`endif

  logic                 BUS_CLK = 1'b0;
  logic                 BUS_RST = 1'b1;
  logic [15:0]          BUS_ADD = '0;
  logic [7:0]           BUS_DATA_IN = '0;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_WR = 1'b0;
  logic                 BUS_RD = 1'b0;
  logic [N_CH-1:0]      CH_STROBE = '0;
  logic [30*N_CH-1:0]   CH_DATA = '0;
  logic [63:0]          TIMESTAMP = 64'h0000_0000_0123_4567;
  logic                 FIFO_READ = 1'b0;
  logic                 FIFO_EMPTY;
  logic [31:0]          FIFO_DATA;
  logic                 LOST_ERROR;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got [$];
  int          first_c;
  int          last_c;
  logic [7:0]  rd;

  always #5 BUS_CLK = ~BUS_CLK;

  mono_data_rx_mux #(.ABUSWIDTH(16), .N_CH(N_CH), .CH_ASIZE(2), .IDENTIFIER(2'b00)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD), .CH_STROBE(CH_STROBE),
    .CH_DATA(CH_DATA), .TIMESTAMP(TIMESTAMP), .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA(FIFO_DATA), .LOST_ERROR(LOST_ERROR)
  );

  function automatic logic [31:0] mk(input logic [1:0] t, input int ch, input logic [23:0] p);
    return {2'b00, t, 4'(ch), p};
  endfunction

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    BUS_ADD = a; BUS_RD = 1'b1;
    tick();
    BUS_RD = 1'b0;
    d = BUS_DATA_OUT;
  endtask

  task automatic strobe(input int ch, input logic [29:0] d);
    CH_DATA[30*ch +: 30] = d;
    CH_STROBE = 4'(1 << ch);
    tick();
    CH_STROBE = '0;
  endtask

  // Pops words with FIFO_READ high until n are collected or the cycle budget runs out.
  task automatic capture(input int n, input int budget);
    got.delete();
    first_c = -1; last_c = -1;
    FIFO_READ = 1'b1;
    for (int c = 0; c < budget && got.size() < n; c++) begin
      if (!FIFO_EMPTY) begin
        if (got.size() == 0) first_c = c;
        got.push_back(FIFO_DATA);
        last_c = c;
      end
      tick();
    end
    FIFO_READ = 1'b0;
  endtask

  task automatic test_reset();
    BUS_RST = 1'b1;
    repeat (3) tick();
    BUS_RST = 1'b0;
    checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", FIFO_EMPTY); end
    checks++; if (FIFO_DATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", FIFO_DATA); end
    checks++; if (BUS_DATA_OUT !== 8'h0) begin errors++; $display("[TB] FAIL reset_busout: got %h want 0", BUS_DATA_OUT); end
    checks++; if (LOST_ERROR !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost_error: got %b want 0", LOST_ERROR); end
    bus_read(16'd0, rd);
    checks++; if (rd !== 8'd1) begin errors++; $display("[TB] FAIL version: got %h want 01", rd); end
    bus_read(16'd2, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL reset_conf_en: got %h want 00", rd); end
    bus_read(16'd1, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL unmapped_1: got %h want 00", rd); end
    bus_read(16'd8, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL unmapped_8: got %h want 00", rd); end
  endtask

  task automatic test_gray();
    bus_write(16'd2, 8'h01);
    FIFO_READ = 1'b1;
    strobe(0, {8'h80, 8'hC0, 8'h12, 6'h05});
    checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL gray_lat_c1: got empty=%b want 1", FIFO_EMPTY); end
    tick();
    checks++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("[TB] FAIL gray_lat_c2: got empty=%b want 0", FIFO_EMPTY); end
    checks++; if (FIFO_DATA !== 32'h10FF8012) begin errors++; $display("[TB] FAIL gray_w1: got %h want 10ff8012", FIFO_DATA); end
    tick();
    checks++; if (FIFO_DATA !== 32'h20000005 || FIFO_EMPTY !== 1'b0) begin errors++; $display("[TB] FAIL gray_w2: got %h empty=%b want 20000005", FIFO_DATA, FIFO_EMPTY); end
`ifdef MONO_RX_MUX_TIMESTAMP_EN
    tick();
    checks++; if (FIFO_DATA !== 32'h30234567) begin errors++; $display("[TB] FAIL gray_w3: got %h want 30234567", FIFO_DATA); end
`endif
    tick();
    checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL gray_drained: got empty=%b want 1", FIFO_EMPTY); end
    bus_write(16'd3, 8'h01);
    strobe(0, {8'h80, 8'hC0, 8'h12, 6'h05});
    tick();
    checks++; if (FIFO_DATA !== 32'h1080C012) begin errors++; $display("[TB] FAIL raw_w1: got %h want 1080c012", FIFO_DATA); end
    repeat (4) tick();
    FIFO_READ = 1'b0;
  endtask

  task automatic test_round_robin();
    bus_write(16'd0, 8'h00);
    bus_write(16'd2, 8'h0F);
    bus_write(16'd3, 8'h01);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < N_CH; k++)
        CH_DATA[30*k +: 30] = {8'(8'hA0 + k), 8'(8'hB0 + k), 8'(8'h10 + k), 6'(k + 1)};
      CH_STROBE = 4'hF;
      tick();
      CH_STROBE = '0;
      capture(4 * WPH, 30);
      checks++; if (got.size() != 4 * WPH) begin errors++; $display("[TB] FAIL rr_count: got %0d want %0d", got.size(), 4 * WPH); end
      checks++; if (last_c - first_c != 4 * WPH - 1) begin errors++; $display("[TB] FAIL rr_b2b_span: got %0d want %0d", last_c - first_c, 4 * WPH - 1); end
      for (int k = 0; k < N_CH; k++) begin
        if (k * WPH + 1 < got.size()) begin
          checks++; if (got[k*WPH] !== mk(2'b01, k, {8'(8'hA0 + k), 8'(8'hB0 + k), 8'(8'h10 + k)})) begin errors++; $display("[TB] FAIL rr_w1 rep%0d ch%0d: got %h", rep, k, got[k*WPH]); end
          checks++; if (got[k*WPH+1] !== mk(2'b10, k, 24'(k + 1))) begin errors++; $display("[TB] FAIL rr_w2 rep%0d ch%0d: got %h", rep, k, got[k*WPH+1]); end
        end
      end
    end
    // last grant becomes ch1, so ch2 must beat ch0 afterwards
    strobe(1, {8'h01, 8'h02, 8'h03, 6'h04});
    capture(WPH, 10);
    CH_DATA[0 +: 30]  = {8'h11, 8'h22, 8'h33, 6'h01};
    CH_DATA[60 +: 30] = {8'h44, 8'h55, 8'h66, 6'h02};
    CH_STROBE = 4'b0101;
    tick();
    CH_STROBE = '0;
    capture(2 * WPH, 20);
    checks++; if (got.size() != 2 * WPH) begin errors++; $display("[TB] FAIL rr_rot_count: got %0d want %0d", got.size(), 2 * WPH); end
    else begin
      checks++; if (got[0] !== mk(2'b01, 2, 24'h445566)) begin errors++; $display("[TB] FAIL rr_rot_first: got %h want %h", got[0], mk(2'b01, 2, 24'h445566)); end
      checks++; if (got[WPH] !== mk(2'b01, 0, 24'h112233)) begin errors++; $display("[TB] FAIL rr_rot_second: got %h want %h", got[WPH], mk(2'b01, 0, 24'h112233)); end
    end
  endtask

  task automatic test_overflow();
    bus_write(16'd0, 8'h00);
    bus_write(16'd2, 8'h03);
    FIFO_READ = 1'b0;
    strobe(0, {8'h00, 8'h00, 8'h55, 6'h03});
    tick();
    for (int i = 0; i < 6; i++) strobe(1, {8'h00, 8'h00, 8'(i), 6'(i)});
    for (int i = 0; i < 3; i++) strobe(2, {8'h00, 8'h00, 8'hEE, 6'h3F});
    bus_read(16'd5, rd);
    checks++; if (rd !== 8'd2) begin errors++; $display("[TB] FAIL lost1_after6: got %0d want 2", rd); end
    bus_read(16'd4, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL lost0: got %0d want 0", rd); end
    bus_read(16'd6, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL lost2_disabled: got %0d want 0", rd); end
    checks++; if (LOST_ERROR !== 1'b1) begin errors++; $display("[TB] FAIL lost_error_set: got %b want 1", LOST_ERROR); end
    for (int i = 0; i < 300; i++) strobe(1, {8'h00, 8'h00, 8'hEE, 6'h3F});
    bus_read(16'd5, rd);
    checks++; if (rd !== 8'd255) begin errors++; $display("[TB] FAIL lost1_saturate: got %0d want 255", rd); end
    capture(5 * WPH, 40);
    checks++; if (got.size() != 5 * WPH) begin errors++; $display("[TB] FAIL ovf_count: got %0d want %0d", got.size(), 5 * WPH); end
    else begin
      checks++; if (got[0] !== 32'h10000055) begin errors++; $display("[TB] FAIL ovf_ch0_w1: got %h want 10000055", got[0]); end
      checks++; if (got[1] !== 32'h20000003) begin errors++; $display("[TB] FAIL ovf_ch0_w2: got %h want 20000003", got[1]); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (got[WPH + i*WPH] !== mk(2'b01, 1, 24'(i))) begin errors++; $display("[TB] FAIL ovf_kept%0d_w1: got %h want %h", i, got[WPH + i*WPH], mk(2'b01, 1, 24'(i))); end
        checks++; if (got[WPH + i*WPH + 1] !== mk(2'b10, 1, 24'(i))) begin errors++; $display("[TB] FAIL ovf_kept%0d_w2: got %h want %h", i, got[WPH + i*WPH + 1], mk(2'b10, 1, 24'(i))); end
      end
    end
  endtask

  task automatic test_soft_reset();
    int seen;
    FIFO_READ = 1'b0;
    strobe(0, {8'h00, 8'h00, 8'h77, 6'h01});
    tick();
    checks++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("[TB] FAIL sr_pre_valid: got empty=%b want 0", FIFO_EMPTY); end
    checks++; if (LOST_ERROR !== 1'b1) begin errors++; $display("[TB] FAIL sr_pre_lost: got %b want 1", LOST_ERROR); end
    bus_write(16'd0, 8'h00);
    checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL sr_empty: got %b want 1", FIFO_EMPTY); end
    checks++; if (FIFO_DATA !== 32'h0) begin errors++; $display("[TB] FAIL sr_data: got %h want 0", FIFO_DATA); end
    checks++; if (LOST_ERROR !== 1'b0) begin errors++; $display("[TB] FAIL sr_lost_error: got %b want 0", LOST_ERROR); end
    bus_read(16'd5, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL sr_lost1: got %0d want 0", rd); end
    bus_read(16'd2, rd);
    checks++; if (rd !== 8'd0) begin errors++; $display("[TB] FAIL sr_conf_en: got %h want 00", rd); end
    seen = 0;
    FIFO_READ = 1'b1;
    CH_STROBE = 4'h3;
    repeat (3) tick();
    CH_STROBE = '0;
    for (int c = 0; c < 6; c++) begin if (!FIFO_EMPTY) seen++; tick(); end
    bus_write(16'd2, 8'h03);
    for (int c = 0; c < 6; c++) begin if (!FIFO_EMPTY) seen++; tick(); end
    FIFO_READ = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL sr_ignored: got %0d words want 0", seen); end
  endtask

  task automatic test_backpressure();
    bus_write(16'd0, 8'h00);
    bus_write(16'd2, 8'h01);
    FIFO_READ = 1'b0;
    for (int h = 0; h < 3; h++) strobe(0, {8'h00, 8'h00, 8'(8'h20 + h), 6'(h + 1)});
    repeat (4) tick();
    checks++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid: got empty=%b want 0", FIFO_EMPTY); end
    checks++; if (FIFO_DATA !== 32'h10000020) begin errors++; $display("[TB] FAIL bp_hold_a: got %h want 10000020", FIFO_DATA); end
    repeat (3) tick();
    checks++; if (FIFO_DATA !== 32'h10000020) begin errors++; $display("[TB] FAIL bp_hold_b: got %h want 10000020", FIFO_DATA); end
    capture(3 * WPH, 20);
    checks++; if (got.size() != 3 * WPH) begin errors++; $display("[TB] FAIL bp_count: got %0d want %0d", got.size(), 3 * WPH); end
    checks++; if (last_c - first_c != 3 * WPH - 1) begin errors++; $display("[TB] FAIL bp_b2b_span: got %0d want %0d", last_c - first_c, 3 * WPH - 1); end
    for (int h = 0; h < 3; h++) begin
      if (h * WPH + 1 < got.size()) begin
        checks++; if (got[h*WPH] !== mk(2'b01, 0, 24'(8'h20 + h))) begin errors++; $display("[TB] FAIL bp_w1_%0d: got %h", h, got[h*WPH]); end
        checks++; if (got[h*WPH+1] !== mk(2'b10, 0, 24'(h + 1))) begin errors++; $display("[TB] FAIL bp_w2_%0d: got %h", h, got[h*WPH+1]); end
      end
    end
  endtask

  task automatic test_disable_mid_hit();
    FIFO_READ = 1'b0;
    strobe(0, {8'h00, 8'h00, 8'h30, 6'h01});
    strobe(0, {8'h00, 8'h00, 8'h31, 6'h02});
    repeat (2) tick();
    bus_write(16'd2, 8'h00);
    capture(2 * WPH, 12);
    checks++; if (got.size() != WPH) begin errors++; $display("[TB] FAIL dis_count: got %0d want %0d", got.size(), WPH); end
    checks++; if (got.size() == 0 || got[0] !== 32'h10000030) begin errors++; $display("[TB] FAIL dis_w1: got %h want 10000030", (got.size() == 0) ? 32'h0 : got[0]); end
    bus_write(16'd2, 8'h01);
    capture(WPH, 10);
    checks++; if (got.size() != WPH || got[0] !== 32'h10000031) begin errors++; $display("[TB] FAIL dis_resume: got %0d words first %h want 10000031", got.size(), (got.size() == 0) ? 32'h0 : got[0]); end
  endtask

`ifdef MONO_RX_MUX_TIMESTAMP_EN
  task automatic test_timestamp();
    bus_write(16'd0, 8'h00);
    bus_write(16'd2, 8'h04);
    strobe(2, {8'h00, 8'h00, 8'h09, 6'h0A});
    capture(3, 10);
    checks++; if (got.size() != 3 || got[2] !== 32'h32234567) begin errors++; $display("[TB] FAIL ts_word: got %0d words last %h want 32234567", got.size(), (got.size() < 3) ? 32'h0 : got[2]); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting");
    test_reset();
    test_gray();
    test_round_robin();
    test_overflow();
    test_soft_reset();
    test_backpressure();
    test_disable_mid_hit();
`ifdef MONO_RX_MUX_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
